pq_cmd_sequencer: RTL and testbench

- Command front-end for the register_tree priority queue (max-heap, root at o_data).
- Accepts ENQ/DEQ/REPLACE/PEEK commands over a valid/ready channel and drives the tree's i_wrt/i_read/i_data strobes for exactly one cycle.
- Enforces the tree's settle time before accepting the next command; rejects illegal ops; returns status, popped value and new root on a valid/ready response channel.
- Sits between host logic and one register_tree instance; both share CLK/RSTn.

---
 rtl/pq_pkg.sv | 39 +++
 rtl/pq_cmd_sequencer_if.sv | 45 ++++
 rtl/pq_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pq_cmd_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared types and settle-latency helper for the priority-queue command sequencer
//
// Purpose: command opcodes, response status codes and FSM state encoding used by
// pq_cmd_sequencer and its bench, plus lat_f(), which gives the number of cycles the
// attached register_tree needs to settle after a strobe.
// Ports: none (package).
package pq_pkg;

    typedef enum logic [1:0] {
        OP_ENQ     = 2'd0,
        OP_DEQ     = 2'd1,
        OP_REPLACE = 2'd2,
        OP_PEEK    = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_OK             = 2'd0,
        ST_ERR_FULL       = 2'd1,
        ST_ERR_EMPTY      = 2'd2,
        ST_OK_REPL_AS_ENQ = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ISSUE  = 2'd1,
        STATE_SETTLE = 2'd2,
        STATE_RESP   = 2'd3
    } state_t;

    // An insert ripples down the full depth of the tree; a read or replace only
    // needs a fixed number of compare/swap stages near the root.
    function automatic int lat_f(input op_t op, input int queue_size);
        if (op == OP_ENQ) begin
            return $clog2(queue_size) + 3;
        end
        return 3;
    endfunction

endpackage

// File: rtl/pq_cmd_sequencer_if.sv
// rtl/pq_cmd_sequencer_if.sv - command, response and tree-strobe bundle for pq_cmd_sequencer
//
// Purpose: groups the host command channel, the host response channel and the
// register_tree strobe/status signals.
// Modports:
//   slave  - the sequencer: takes cmd_*, rsp_ready and tree status, drives cmd_ready,
//            rsp_*, busy and the tree strobes.
//   master - the host and tree side: the mirror image of slave.
interface pq_cmd_sequencer_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [DATA_WIDTH-1:0] cmd_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_status;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [DATA_WIDTH-1:0] rsp_top;

    logic                  busy;

    logic                  pq_wrt;
    logic                  pq_read;
    logic [DATA_WIDTH-1:0] pq_data;
    logic                  pq_full;
    logic                  pq_empty;
    logic [DATA_WIDTH-1:0] pq_root;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready, pq_full, pq_empty, pq_root,
        output cmd_ready, rsp_valid, rsp_status, rsp_data, rsp_top, busy,
               pq_wrt, pq_read, pq_data
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready, pq_full, pq_empty, pq_root,
        input  cmd_ready, rsp_valid, rsp_status, rsp_data, rsp_top, busy,
               pq_wrt, pq_read, pq_data
    );

endinterface

// File: rtl/pq_cmd_sequencer.sv
// rtl/pq_cmd_sequencer.sv - command front-end that strobes a register_tree priority queue
//
// Purpose: accepts ENQ/DEQ/REPLACE/PEEK commands, rejects illegal ones, pulses the
// tree's i_wrt/i_read for one cycle, waits out the tree's settle time and returns
// status, the pre-op root and the settled root on the response channel.
// Ports:
//   CLK   - clock shared with the tree.
//   RSTn  - asynchronous active-low reset, shared with the tree.
//   bus   - pq_cmd_sequencer_if.slave: cmd_valid/cmd_ready/cmd_op/cmd_data in,
//           rsp_valid/rsp_ready/rsp_status/rsp_data/rsp_top out, busy out,
//           pq_wrt/pq_read/pq_data to the tree, pq_full/pq_empty/pq_root from it.
module pq_cmd_sequencer
    import pq_pkg::*;
#(
    parameter int QUEUE_SIZE = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ENQ_LAT    = lat_f(OP_ENQ, QUEUE_SIZE),
    parameter int DEQ_LAT    = lat_f(OP_DEQ, QUEUE_SIZE)
) (
    input  logic              CLK,
    input  logic              RSTn,
    pq_cmd_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE   = STATE_IDLE;
    localparam logic [1:0] S_ISSUE  = STATE_ISSUE;
    localparam logic [1:0] S_SETTLE = STATE_SETTLE;
    localparam logic [1:0] S_RESP   = STATE_RESP;

    localparam int LAT_MAX = (ENQ_LAT > DEQ_LAT) ? ENQ_LAT : DEQ_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_long;
    logic                  r_ins_only;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_status;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [DATA_WIDTH-1:0] r_rsp_top;
    logic                  r_busy;
    logic                  r_pq_wrt;
    logic                  r_pq_read;
    logic [DATA_WIDTH-1:0] r_pq_data;

    // Classification of the offered command against the tree flags as seen this cycle.
    // w_direct: no strobe is issued (rejects and PEEK).
    logic       w_direct;
    logic       w_wrt;
    logic       w_read;
    logic       w_long;
    logic [1:0] w_status;

    always_comb begin
        w_direct = 1'b0;
        w_wrt    = 1'b0;
        w_read   = 1'b0;
        w_long   = 1'b0;
        w_status = ST_OK;
        case (bus.cmd_op)
            OP_ENQ: begin
                if (bus.pq_full) begin
                    w_direct = 1'b1;
                    w_status = ST_ERR_FULL;
                end else begin
                    w_wrt  = 1'b1;
                    w_long = 1'b1;
                end
            end
            OP_DEQ: begin
                if (bus.pq_empty) begin
                    w_direct = 1'b1;
                    w_status = ST_ERR_EMPTY;
                end else begin
                    w_read = 1'b1;
                end
            end
            OP_REPLACE: begin
                // Nothing to pop from an empty tree: degrade to a plain insert.
                if (bus.pq_empty) begin
                    w_wrt    = 1'b1;
                    w_long   = 1'b1;
                    w_status = ST_OK_REPL_AS_ENQ;
                end else begin
                    w_wrt  = 1'b1;
                    w_read = 1'b1;
                end
            end
            default: begin
                w_direct = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_long       <= 1'b0;
            r_ins_only   <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= '0;
            r_rsp_data   <= '0;
            r_rsp_top    <= '0;
            r_busy       <= 1'b0;
            r_pq_wrt     <= 1'b0;
            r_pq_read    <= 1'b0;
            r_pq_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cmd_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_rsp_status <= w_status;
                        if (w_direct) begin
                            // Rejects and PEEK spend one zero-count SETTLE cycle so that
                            // every response lands a counted number of edges after accept.
                            r_state    <= S_SETTLE;
                            r_cnt      <= '0;
                            r_rsp_data <= (bus.cmd_op == OP_PEEK) ? bus.pq_root : '0;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_pq_wrt   <= w_wrt;
                            r_pq_read  <= w_read;
                            r_pq_data  <= bus.cmd_data;
                            r_long     <= w_long;
                            r_ins_only <= w_wrt & ~w_read;
                        end
                    end
                end
                S_ISSUE: begin
                    // The tree samples the strobe on this same edge, so pq_root is
                    // still the pre-op root here.
                    r_pq_wrt   <= 1'b0;
                    r_pq_read  <= 1'b0;
                    r_rsp_data <= r_ins_only ? '0 : bus.pq_root;
                    r_cnt      <= r_long ? CNT_W'(ENQ_LAT - 1) : CNT_W'(DEQ_LAT - 1);
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_top   <= bus.pq_root;
                        r_rsp_valid <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_top    = r_rsp_top;
    assign bus.busy       = r_busy;
    assign bus.pq_wrt     = r_pq_wrt;
    assign bus.pq_read    = r_pq_read;
    assign bus.pq_data    = r_pq_data;

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// tb/tb_pq_cmd_sequencer.sv - scoreboard bench for pq_cmd_sequencer with a behavioural tree
module tb_pq_cmd_sequencer;
    import pq_pkg::*;

    localparam int QS      = 16;
    localparam int DW      = 16;
    localparam int ENQ_LAT = $clog2(QS) + 3;
    localparam int DEQ_LAT = 3;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;
    always #5 CLK = ~CLK;

    pq_cmd_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    pq_cmd_sequencer #(
        .QUEUE_SIZE(QS),
        .DATA_WIDTH(DW),
        .ENQ_LAT   (ENQ_LAT),
        .DEQ_LAT   (DEQ_LAT)
    ) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic void chk(input string name, input longint unsigned act, input longint unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Behavioural register_tree: contents change on the strobe edge, but the root
    // output reads as garbage until the tree's settle time has elapsed.
    logic [DW-1:0] tmem [QS];
    int            tcnt;
    int            tbusy;
    int            t_mi;

    always_comb begin
        t_mi = 0;
        for (int i = 1; i < QS; i++) begin
            if (i < tcnt && tmem[i] > tmem[t_mi]) t_mi = i;
        end
    end

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tcnt  <= 0;
            tbusy <= 0;
        end else begin
            if (tbusy != 0) tbusy <= tbusy - 1;
            if (bus.pq_wrt || bus.pq_read) begin
                if (bus.pq_wrt && bus.pq_read) begin
                    tmem[t_mi] <= bus.pq_data;
                end else if (bus.pq_read) begin
                    tmem[t_mi] <= tmem[tcnt-1];
                    tcnt       <= tcnt - 1;
                end else begin
                    tmem[tcnt] <= bus.pq_data;
                    tcnt       <= tcnt + 1;
                end
                tbusy <= (bus.pq_wrt && !bus.pq_read) ? ENQ_LAT - 1 : DEQ_LAT - 1;
            end
        end
    end

    assign bus.pq_root  = (tbusy != 0) ? 16'hBAD0 : ((tcnt == 0) ? '0 : tmem[t_mi]);
    assign bus.pq_full  = (tcnt >= QS);
    assign bus.pq_empty = (tcnt == 0);

    // Reference model: a descending-sorted list of what the queue should hold.
    typedef struct {
        logic [1:0]    st;
        logic [DW-1:0] d;
        logic [DW-1:0] t;
        int            lat;
        int            nw;
        int            nr;
        int            acc;
    } exp_t;

    logic [DW-1:0] ref_q[$];
    exp_t          exp_q[$];

    logic hold    = 1'b0;
    logic rnd_rdy = 1'b0;

    initial forever begin
        @(posedge CLK);
        #1;
        bus.rsp_ready = hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Monitor: pops one expectation when a response first appears, then checks the
    // payload stays put until the handshake.
    logic          in_rsp = 1'b0;
    int            wcnt   = 0;
    int            rcnt   = 0;
    exp_t          me;
    logic [1:0]    s_st;
    logic [DW-1:0] s_d;
    logic [DW-1:0] s_t;

    initial forever begin
        @(negedge CLK);
        if (!RSTn) begin
            in_rsp = 1'b0;
            wcnt   = 0;
            rcnt   = 0;
        end else begin
            if (bus.pq_wrt)  wcnt++;
            if (bus.pq_read) rcnt++;
            if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    s_st   = bus.rsp_status;
                    s_d    = bus.rsp_data;
                    s_t    = bus.rsp_top;
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        me = exp_q.pop_front();
                        chk("rsp_status",  bus.rsp_status, me.st);
                        chk("rsp_data",    bus.rsp_data,   me.d);
                        chk("rsp_top",     bus.rsp_top,    me.t);
                        chk("rsp_latency", cyc - me.acc,   me.lat);
                        chk("wrt_cycles",  wcnt,           me.nw);
                        chk("read_cycles", rcnt,           me.nr);
                    end
                    wcnt = 0;
                    rcnt = 0;
                end else begin
                    chk("rsp_stable", {bus.rsp_status, bus.rsp_data, bus.rsp_top}, {s_st, s_d, s_t});
                end
                if (bus.rsp_ready) in_rsp = 1'b0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] v);
        exp_t e;
        int   g;
        g = 0;
        while (bus.cmd_ready !== 1'b1) begin
            @(posedge CLK);
            #1;
            g++;
            if (g > 300) begin
                chk("cmd_ready_timeout", 0, 1);
                return;
            end
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = v;
        @(posedge CLK);
        #1;
        bus.cmd_valid = 1'b0;
        e.acc = cyc;
        e.d   = '0;
        e.nw  = 0;
        e.nr  = 0;
        e.lat = 1;
        e.st  = ST_OK;
        case (op)
            OP_ENQ: begin
                if (ref_q.size() >= QS) begin
                    e.st = ST_ERR_FULL;
                end else begin
                    ref_q.push_back(v);
                    ref_q.rsort();
                    e.lat = ENQ_LAT + 1;
                    e.nw  = 1;
                end
            end
            OP_DEQ: begin
                if (ref_q.size() == 0) begin
                    e.st = ST_ERR_EMPTY;
                end else begin
                    e.d = ref_q.pop_front();
                    e.lat = DEQ_LAT + 1;
                    e.nr  = 1;
                end
            end
            OP_REPLACE: begin
                e.nw = 1;
                if (ref_q.size() == 0) begin
                    ref_q.push_back(v);
                    e.st  = ST_OK_REPL_AS_ENQ;
                    e.lat = ENQ_LAT + 1;
                end else begin
                    e.d      = ref_q[0];
                    ref_q[0] = v;
                    ref_q.rsort();
                    e.lat    = DEQ_LAT + 1;
                    e.nr     = 1;
                end
            end
            default: begin
                e.d = (ref_q.size() != 0) ? ref_q[0] : '0;
            end
        endcase
        e.t = (ref_q.size() != 0) ? ref_q[0] : '0;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || in_rsp || bus.cmd_ready !== 1'b1) && g < 1000) begin
            @(posedge CLK);
            #1;
            g++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        #2;
        RSTn = 1'b0;
        #1;
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_busy",      bus.busy,      0);
        chk("reset_strobes",   {bus.pq_wrt, bus.pq_read}, 0);
        chk("reset_payload",   {bus.rsp_status, bus.rsp_data, bus.rsp_top, bus.pq_data}, 0);
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        issue(OP_PEEK, 16'd0);

        issue(OP_ENQ, 16'd100);
        issue(OP_ENQ, 16'd700);
        issue(OP_ENQ, 16'd300);

        repeat (4) issue(OP_DEQ, 16'd0);

        for (int i = 0; i < QS; i++) issue(OP_ENQ, 16'($urandom_range(0, 1000)));
        issue(OP_ENQ, 16'd5);
        issue(OP_REPLACE, 16'd1023);
        for (int i = 0; i < QS; i++) issue(OP_DEQ, 16'd0);
        issue(OP_REPLACE, 16'd42);
        drain();

        // Response back-pressure: payload must hold and new commands must be ignored.
        hold = 1'b1;
        @(posedge CLK);
        #1;
        issue(OP_PEEK, 16'd0);
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = OP_ENQ;
            bus.cmd_data  = 16'd999;
            @(posedge CLK);
            #1;
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
        end
        bus.cmd_valid = 1'b0;
        hold = 1'b0;
        drain();

        // Reset in the middle of an insert's settle window.
        issue(OP_ENQ, 16'd77);
        repeat (3) @(posedge CLK);
        #2;
        chk("settle_busy",      bus.busy,      1);
        chk("settle_rsp_valid", bus.rsp_valid, 0);
        RSTn = 1'b0;
        #1;
        chk("midrst_busy",      bus.busy,      0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_strobes",   {bus.pq_wrt, bus.pq_read}, 0);
        exp_q.delete();
        ref_q.delete();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        issue(OP_PEEK, 16'd0);
        drain();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      issue(OP_ENQ,     16'($urandom_range(0, 65535)));
            else if (r < 7) issue(OP_DEQ,     16'd0);
            else if (r < 9) issue(OP_REPLACE, 16'($urandom_range(0, 65535)));
            else            issue(OP_PEEK,    16'd0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
